// File: rtl/skid_fifo_if.sv
// Valid/ready stream bundle for skid_fifo: upstream (input_*) and downstream (output_*) handshakes.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface skid_fifo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             input_valid_i;
  logic             input_ready_o;
  logic [WIDTH-1:0] input_data_i;
  logic             output_valid_o;
  logic             output_ready_i;
  logic [WIDTH-1:0] output_data_o;

  modport slave (
    input  input_valid_i,
    input  input_data_i,
    input  output_ready_i,
    output input_ready_o,
    output output_valid_o,
    output output_data_o
  );

  modport master (
    output input_valid_i,
    output input_data_i,
    output output_ready_i,
    input  input_ready_o,
    input  output_valid_o,
    input  output_data_o
  );
endinterface

// File: rtl/skid_fifo.sv
// Parametrised N-entry elastic buffer with fully registered ready/valid on both sides.
// Optional SKID_FIFO_LEVEL_EN adds registered level_o / almost_full_o outputs.
module skid_fifo #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_LEVEL = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  skid_fifo_if.slave                 io
`ifdef SKID_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       almost_full_o
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop, mem_we;

  assign push = io.input_valid_i & in_ready_q;
  assign pop  = out_valid_q & io.output_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_we   = 1'b1;
        // explicit wrap keeps non-power-of-2 depths in range
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    in_ready_d  = (32'(count_d) < DEPTH);
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= io.input_data_i;
    end
  end

  assign io.input_ready_o  = in_ready_q;
  assign io.output_valid_o = out_valid_q;
  assign io.output_data_o  = mem_q[rd_ptr_q];

`ifdef SKID_FIFO_LEVEL_EN
  logic [CNT_W-1:0] level_q;
  logic             almost_full_q, almost_full_d;

  assign almost_full_d = (32'(count_d) >= AFULL_LEVEL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign level_o       = level_q;
  assign almost_full_o = almost_full_q;
`endif

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (32'(count_q) == DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && (count_q == '0)));
  a_params: assert property (@(posedge clk_i)
    (DEPTH >= 2) && (AFULL_LEVEL >= 1) && (AFULL_LEVEL <= DEPTH));

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench: queue model per DUT checked every cycle, plus directed literal checks.
module tb_skid_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  skid_fifo_if #(.WIDTH(32)) if4 ();
  skid_fifo_if #(.WIDTH(16)) if3 ();

`ifdef SKID_FIFO_LEVEL_EN
  logic [2:0] lvl4;
  logic       af4;
  logic [1:0] lvl3;
  logic       af3;
`endif

  skid_fifo #(.WIDTH(32), .DEPTH(4), .AFULL_LEVEL(3)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .io(if4.slave)
`ifdef SKID_FIFO_LEVEL_EN
    , .level_o(lvl4), .almost_full_o(af4)
`endif
  );

  skid_fifo #(.WIDTH(16), .DEPTH(3), .AFULL_LEVEL(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .io(if3.slave)
`ifdef SKID_FIFO_LEVEL_EN
    , .level_o(lvl3), .almost_full_o(af3)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queues ----------------
  logic [31:0] q4[$];
  logic [31:0] q3[$];
  bit s4 = 0, s3 = 0;           // accepting since the first edge after reset
  bit pushed4 = 0, pushed3 = 0;
  int pops4 = 0, pops3 = 0;

  always @(negedge rst_n) begin
    q4.delete(); q3.delete();
    s4 = 0; s3 = 0; pushed4 = 0; pushed3 = 0;
  end

  always @(posedge clk) begin
    bit p, o;
    if (!rst_n) begin
      q4.delete(); s4 = 0; pushed4 = 0;
    end else if (clear) begin
      q4.delete(); s4 = 1; pushed4 = 0;
    end else begin
      p = if4.input_valid_i && s4 && (q4.size() < 4);
      o = (q4.size() != 0) && if4.output_ready_i;
      if (o) begin void'(q4.pop_front()); pops4++; end
      if (p) q4.push_back(if4.input_data_i);
      pushed4 = p;
      s4 = 1;
    end
  end

  always @(posedge clk) begin
    bit p, o;
    if (!rst_n) begin
      q3.delete(); s3 = 0; pushed3 = 0;
    end else if (clear) begin
      q3.delete(); s3 = 1; pushed3 = 0;
    end else begin
      p = if3.input_valid_i && s3 && (q3.size() < 3);
      o = (q3.size() != 0) && if3.output_ready_i;
      if (o) begin void'(q3.pop_front()); pops3++; end
      if (p) q3.push_back({16'h0, if3.input_data_i});
      pushed3 = p;
      s3 = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("d4_ready", {31'h0, if4.input_ready_o}, {31'h0, s4 && (q4.size() < 4)});
      check("d4_valid", {31'h0, if4.output_valid_o}, {31'h0, q4.size() != 0});
      if (q4.size() != 0) check("d4_data", if4.output_data_o, q4[0]);
      check("d3_ready", {31'h0, if3.input_ready_o}, {31'h0, s3 && (q3.size() < 3)});
      check("d3_valid", {31'h0, if3.output_valid_o}, {31'h0, q3.size() != 0});
      if (q3.size() != 0) check("d3_data", {16'h0, if3.output_data_o}, q3[0]);
`ifdef SKID_FIFO_LEVEL_EN
      check("d4_level", {29'h0, lvl4}, q4.size());
      check("d4_afull", {31'h0, af4}, {31'h0, q4.size() >= 3});
      check("d3_level", {30'h0, lvl3}, q3.size());
      check("d3_afull", {31'h0, af3}, {31'h0, q3.size() >= 2});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base, sent;
    if4.input_valid_i = 0; if4.input_data_i = '0; if4.output_ready_i = 0;
    if3.input_valid_i = 0; if3.input_data_i = '0; if3.output_ready_i = 0;
    step(); step();
    chk_en = 1;
    check("rst_ready", {31'h0, if4.input_ready_o}, 32'd0);
    check("rst_valid", {31'h0, if4.output_valid_o}, 32'd0);
    rst_n = 1;
    #1 check("rel_ready_pre", {31'h0, if4.input_ready_o}, 32'd0);
    step();
    check("rel_ready_post", {31'h0, if4.input_ready_o}, 32'd1);

    // Fill with downstream stalled
    for (int i = 0; i < 4; i++) begin
      if4.input_valid_i = 1; if4.input_data_i = 32'hA0 + i;
      step();
    end
    check("fill_ready", {31'h0, if4.input_ready_o}, 32'd0);
    check("fill_valid", {31'h0, if4.output_valid_o}, 32'd1);
    check("fill_head", if4.output_data_o, 32'hA0);
`ifdef SKID_FIFO_LEVEL_EN
    check("fill_level", {29'h0, lvl4}, 32'd4);
    check("fill_afull", {31'h0, af4}, 32'd1);
`endif
    if4.input_data_i = 32'hA4;
    step(); step();
    check("full_hold_ready", {31'h0, if4.input_ready_o}, 32'd0);
    check("full_hold_head", if4.output_data_o, 32'hA0);

    // Drain in order; A4 enters once space appears
    if4.output_ready_i = 1;
    step();
    check("drain0_ready", {31'h0, if4.input_ready_o}, 32'd1);
    check("drain0_head", if4.output_data_o, 32'hA1);
    step();
    check("a4_taken", {31'h0, pushed4}, 32'd1);
    check("drain1_head", if4.output_data_o, 32'hA2);
    if4.input_valid_i = 0;
    step(); check("drain2_head", if4.output_data_o, 32'hA3);
    step(); check("drain3_head", if4.output_data_o, 32'hA4);
    step(); check("drain_empty", {31'h0, if4.output_valid_o}, 32'd0);

    // Streaming: 1 beat/cycle, 1-cycle latency
    base = pops4;
    for (int i = 0; i < 100; i++) begin
      if4.input_valid_i = 1; if4.input_data_i = 32'h100 + i;
      step();
      check("stream_valid", {31'h0, if4.output_valid_o}, 32'd1);
      check("stream_data", if4.output_data_o, 32'h100 + i);
    end
    if4.input_valid_i = 0;
    step();
    check("stream_pops", pops4 - base, 32'd100);
    check("stream_empty", {31'h0, if4.output_valid_o}, 32'd0);

    // Reset mid-stream with 3 beats held
    if4.output_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      if4.input_valid_i = 1; if4.input_data_i = 32'hB0 + i;
      step();
    end
    if4.input_data_i = 32'hB3;
    rst_n = 0;
    #1;
    check("mid_rst_valid", {31'h0, if4.output_valid_o}, 32'd0);
    check("mid_rst_ready", {31'h0, if4.input_ready_o}, 32'd0);
`ifdef SKID_FIFO_LEVEL_EN
    check("mid_rst_level", {29'h0, lvl4}, 32'd0);
`endif
    step();
    check("mid_rst_ready2", {31'h0, if4.input_ready_o}, 32'd0);
    rst_n = 1; if4.input_valid_i = 0;
    #1 check("mid_rel_ready_pre", {31'h0, if4.input_ready_o}, 32'd0);
    step();
    check("mid_rel_ready", {31'h0, if4.input_ready_o}, 32'd1);
    check("mid_rel_valid", {31'h0, if4.output_valid_o}, 32'd0);

    // Clear with concurrent push and pop
    for (int i = 0; i < 2; i++) begin
      if4.input_valid_i = 1; if4.input_data_i = 32'hC0 + i;
      step();
    end
    if4.input_data_i = 32'hC2; if4.output_ready_i = 1; clear = 1;
    base = pops4;
    step();
    check("clr_valid", {31'h0, if4.output_valid_o}, 32'd0);
    check("clr_ready", {31'h0, if4.input_ready_o}, 32'd1);
    check("clr_no_pop", pops4 - base, 32'd0);
`ifdef SKID_FIFO_LEVEL_EN
    check("clr_level", {29'h0, lvl4}, 32'd0);
`endif
    clear = 0; if4.input_valid_i = 0;
    step();
    check("clr_dropped", {31'h0, if4.output_valid_o}, 32'd0);
    if4.output_ready_i = 0;

    // DEPTH=3 wrap with random valid/ready, upstream holds until accepted
    base = pops3; sent = 0;
    for (int cyc = 0; cyc < 20000 && (pops3 - base) < 1000; cyc++) begin
      if (!if3.input_valid_i || pushed3) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          if3.input_valid_i = 1; if3.input_data_i = 16'(sent * 37 + 5); sent++;
        end else begin
          if3.input_valid_i = 0;
        end
      end
      if3.output_ready_i = ($urandom_range(0, 2) != 0);
      step();
    end
    check("wrap_beats", pops3 - base, 32'd1000);
    if3.input_valid_i = 0; if3.output_ready_i = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
